// File: rtl/ram_ctrl_pkg.sv
// Shared types and defaults for the RAM4W16B arbiter slice.
// Holds the controller state encoding and the request bundle layout.
package ram_ctrl_pkg;

  localparam int WIDTH_DEF  = 16;
  localparam int AWIDTH_DEF = 2;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    ACK  = 2'd2
  } state_t;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [AWIDTH_DEF-1:0] addr;
    logic [WIDTH_DEF-1:0]  wdata;
  } req_t;

endpackage

// File: rtl/ram4w16b_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker.
// With both requesters valid the one named by prio wins; otherwise the lone valid one.
module rr_pick2 (
  input  logic valid0,
  input  logic valid1,
  input  logic prio,
  output logic gnt_valid,
  output logic gnt_id
);

  assign gnt_valid = valid0 | valid1;
  assign gnt_id    = (valid0 & valid1) ? prio : valid1;

endmodule

// File: rtl/ram4w16b_arbiter.sv
// Two-requester arbiter/sequencer in front of a RAM4W16B: clears every word after
// reset, then serves single-word accesses round-robin at one access per two cycles.
module ram4w16b_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [AWIDTH-1:0] req0_addr,
  input  logic [WIDTH-1:0]  req0_wdata,
  output logic              ack0,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [AWIDTH-1:0] req1_addr,
  input  logic [WIDTH-1:0]  req1_wdata,
  output logic              ack1,
  output logic [WIDTH-1:0]  rdata,
  output logic              init_done,
  output logic [WIDTH-1:0]  ram_in,
  output logic [AWIDTH-1:0] ram_addr,
  output logic              ram_load,
  input  logic [WIDTH-1:0]  ram_out
);

  localparam logic [AWIDTH-1:0] LAST_WORD = {AWIDTH{1'b1}};

  state_t            state, state_nx;
  logic [AWIDTH-1:0] init_cnt;
  logic              prio;
  logic              gnt_id;
  logic              pick_valid;
  logic              pick_id;
  logic              grant;

  rr_pick2 u_pick (
    .valid0    (req0_valid),
    .valid1    (req1_valid),
    .prio      (prio),
    .gnt_valid (pick_valid),
    .gnt_id    (pick_id)
  );

  // Reset forces INIT with init_cnt=0, so the RAM sees load=1, addr=0, data=0 while held.
  always_comb begin
    state_nx = state;
    ram_load = 1'b0;
    ram_addr = '0;
    ram_in   = '0;
    grant    = 1'b0;
    case (state)
      INIT: begin
        ram_load = 1'b1;
        ram_addr = init_cnt;
        if (init_cnt == LAST_WORD) state_nx = IDLE;
      end
      IDLE: begin
        if (pick_valid) begin
          grant    = 1'b1;
          state_nx = ACK;
          if (pick_id) begin
            ram_addr = req1_addr;
            ram_in   = req1_wdata;
            ram_load = req1_we;
          end else begin
            ram_addr = req0_addr;
            ram_in   = req0_wdata;
            ram_load = req0_we;
          end
        end
      end
      ACK:     state_nx = IDLE;
      default: state_nx = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= INIT;
      init_cnt  <= '0;
      prio      <= 1'b0;
      gnt_id    <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata     <= '0;
      init_done <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == INIT) begin
        init_cnt <= init_cnt + 1'b1;
        if (init_cnt == LAST_WORD) init_done <= 1'b1;
      end
      // Only the requester served last holds an ack, so clearing it ends the pulse.
      if (state == ACK) begin
        if (gnt_id) ack1 <= 1'b0;
        else        ack0 <= 1'b0;
      end
      // rdata captures the pre-write contents, also on write grants.
      if (grant) begin
        rdata  <= ram_out;
        gnt_id <= pick_id;
        prio   <= ~pick_id;
        if (pick_id) ack1 <= 1'b1;
        else         ack0 <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ram4w16b_arbiter.sv
// Directed bench for ram4w16b_arbiter with a RAM4W16B model and a transaction-level
// reference model compared every cycle, plus hand-computed literal expectations.
module tb_ram4w16b_arbiter;

  localparam int W  = 16;
  localparam int AW = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req0_valid = 1'b0, req0_we = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic [W-1:0]  req0_wdata = '0;
  logic          req1_valid = 1'b0, req1_we = 1'b0;
  logic [AW-1:0] req1_addr = '0;
  logic [W-1:0]  req1_wdata = '0;
  logic          ack0, ack1, init_done, ram_load;
  logic [W-1:0]  rdata, ram_in, ram_out;
  logic [AW-1:0] ram_addr;

  int vectors = 0;
  int miscompares = 0;
  bit run_cmp = 1'b0;

  always #5 clk = ~clk;

  ram4w16b_arbiter #(.WIDTH(W), .AWIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .ack0       (ack0),
    .req1_valid (req1_valid),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .ack1       (ack1),
    .rdata      (rdata),
    .init_done  (init_done),
    .ram_in     (ram_in),
    .ram_addr   (ram_addr),
    .ram_load   (ram_load),
    .ram_out    (ram_out)
  );

  // RAM4W16B: combinational read, write on rising edge when load is high
  logic [W-1:0] ram [DEPTH];
  assign ram_out = ram[ram_addr];
  always @(posedge clk) if (ram_load) ram[ram_addr] <= ram_in;

  // Reference model: sweep countdown, then one transaction per request followed by an ack cycle
  int           init_left;
  logic         exp_done, exp_ack0, exp_ack1, prio_m;
  logic [W-1:0] exp_rdata;
  logic [W-1:0] mem_m [DEPTH];
  logic         m_id;
  logic         m_we;
  logic [AW-1:0] m_addr;
  logic [W-1:0] m_wd;

  assign m_id   = (req0_valid && req1_valid) ? prio_m : req1_valid;
  assign m_we   = m_id ? req1_we : req0_we;
  assign m_addr = m_id ? req1_addr : req0_addr;
  assign m_wd   = m_id ? req1_wdata : req0_wdata;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      init_left <= DEPTH;
      exp_done  <= 1'b0;
      exp_ack0  <= 1'b0;
      exp_ack1  <= 1'b0;
      exp_rdata <= '0;
      prio_m    <= 1'b0;
      mem_m[0]  <= '0;
    end else begin
      exp_ack0 <= 1'b0;
      exp_ack1 <= 1'b0;
      if (init_left > 0) begin
        mem_m[DEPTH - init_left] <= '0;
        init_left <= init_left - 1;
        if (init_left == 1) exp_done <= 1'b1;
      end else if (!(exp_ack0 || exp_ack1) && (req0_valid || req1_valid)) begin
        exp_rdata <= mem_m[m_addr];
        if (m_we) mem_m[m_addr] <= m_wd;
        if (m_id) exp_ack1 <= 1'b1;
        else      exp_ack0 <= 1'b1;
        prio_m <= ~m_id;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run_cmp && !reset) begin
      chk("cmp_ack0", {31'd0, ack0}, {31'd0, exp_ack0});
      chk("cmp_ack1", {31'd0, ack1}, {31'd0, exp_ack1});
      chk("cmp_init_done", {31'd0, init_done}, {31'd0, exp_done});
      chk("cmp_rdata", {16'd0, rdata}, {16'd0, exp_rdata});
      if (init_left > 0) begin
        chk("cmp_sweep_load", {31'd0, ram_load}, 32'd1);
        chk("cmp_sweep_addr", {30'd0, ram_addr}, DEPTH - init_left);
      end
      if (exp_ack0 || exp_ack1) chk("cmp_ack_noload", {31'd0, ram_load}, 32'd0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_req(input bit port, input bit v, input bit we,
                         input logic [AW-1:0] a, input logic [W-1:0] wd);
    if (port) begin
      req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = wd;
    end else begin
      req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = wd;
    end
  endtask

  task automatic access(input bit port, input bit we, input logic [AW-1:0] a,
                        input logic [W-1:0] wd, output logic [W-1:0] rd);
    bit got;
    got = 1'b0;
    rd = 'x;
    set_req(port, 1'b1, we, a, wd);
    for (int i = 0; i < 10 && !got; i++) begin
      cyc(1);
      if (port ? ack1 : ack0) begin
        got = 1'b1;
        rd = rdata;
      end
    end
    set_req(port, 1'b0, 1'b0, '0, '0);
    if (!got) chk("access_timeout", 32'd0, 32'd1);
  endtask

  logic [W-1:0] rd;
  int n0, n1, nboth, first_id;
  bit got;

  initial begin
    // Reset state and sweep
    reset = 1'b1;
    #2;
    run_cmp = 1'b1;
    cyc(2);
    chk("rst_load", {31'd0, ram_load}, 32'd1);
    chk("rst_addr", {30'd0, ram_addr}, 32'd0);
    chk("rst_in", {16'd0, ram_in}, 32'd0);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_acks", {30'd0, ack1, ack0}, 32'd0);
    chk("rst_rdata", {16'd0, rdata}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      chk("sweep_addr", {30'd0, ram_addr}, i);
      chk("sweep_load", {31'd0, ram_load}, 32'd1);
      chk("sweep_not_done", {31'd0, init_done}, 32'd0);
      cyc(1);
    end
    chk("sweep_done", {31'd0, init_done}, 32'd1);
    chk("idle_noload", {31'd0, ram_load}, 32'd0);
    for (int i = 0; i < DEPTH; i++) chk("sweep_word_zero", {16'd0, ram[i]}, 32'd0);

    // Write then read back
    access(1'b0, 1'b1, 2'd0, 16'h5555, rd);
    chk("wr0_old", {16'd0, rd}, 32'h0000);
    access(1'b0, 1'b0, 2'd0, 16'h0000, rd);
    chk("rd0_new", {16'd0, rd}, 32'h5555);
    access(1'b1, 1'b0, 2'd3, 16'h0000, rd);
    chk("rd3_zero", {16'd0, rd}, 32'h0000);

    // Simultaneous writes: prio now favours requester 0
    cyc(1);
    set_req(1'b0, 1'b1, 1'b1, 2'd1, 16'hFFFF);
    set_req(1'b1, 1'b1, 1'b1, 2'd2, 16'hAAAA);
    cyc(1);
    chk("both_first_ack0", {30'd0, ack1, ack0}, 32'b01);
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    cyc(1);
    chk("both_gap", {30'd0, ack1, ack0}, 32'b00);
    cyc(1);
    chk("both_second_ack1", {30'd0, ack1, ack0}, 32'b10);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    access(1'b0, 1'b0, 2'd1, 16'h0000, rd);
    chk("rd1_ffff", {16'd0, rd}, 32'hFFFF);
    access(1'b1, 1'b0, 2'd2, 16'h0000, rd);
    chk("rd2_aaaa", {16'd0, rd}, 32'hAAAA);

    // Continuous contention for 8 cycles
    cyc(1);
    n0 = 0; n1 = 0; nboth = 0; first_id = -1;
    set_req(1'b0, 1'b1, 1'b0, 2'd0, 16'h0000);
    set_req(1'b1, 1'b1, 1'b0, 2'd1, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if (ack0) n0++;
      if (ack1) n1++;
      if (ack0 && ack1) nboth++;
      if (first_id < 0 && (ack0 || ack1)) first_id = ack1 ? 1 : 0;
    end
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    chk("rr_n0", n0, 32'd2);
    chk("rr_n1", n1, 32'd2);
    chk("rr_both", nboth, 32'd0);
    chk("rr_first", first_id, 32'd0);

    // Request raised during the sweep
    cyc(1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(1);
    set_req(1'b1, 1'b1, 1'b1, 2'd3, 16'h0FF0);
    cyc(3);
    chk("init_req_no_ack", {31'd0, ack1}, 32'd0);
    chk("init_req_done", {31'd0, init_done}, 32'd1);
    cyc(1);
    chk("init_req_ack1", {31'd0, ack1}, 32'd1);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    access(1'b1, 1'b0, 2'd3, 16'h0000, rd);
    chk("rd3_0ff0", {16'd0, rd}, 32'h0FF0);
    access(1'b0, 1'b0, 2'd1, 16'h0000, rd);
    chk("rd1_cleared", {16'd0, rd}, 32'h0000);

    // Reset asserted during the ack cycle
    set_req(1'b0, 1'b1, 1'b1, 2'd0, 16'h1234);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      cyc(1);
      if (ack0) got = 1'b1;
    end
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    if (!got) chk("ackrst_timeout", 32'd0, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("ackrst_ack0", {31'd0, ack0}, 32'd0);
    chk("ackrst_init_done", {31'd0, init_done}, 32'd0);
    cyc(1);
    reset = 1'b0;
    cyc(4);
    chk("ackrst_redone", {31'd0, init_done}, 32'd1);
    access(1'b0, 1'b0, 2'd0, 16'h0000, rd);
    chk("ackrst_rd0", {16'd0, rd}, 32'h0000);
    access(1'b1, 1'b0, 2'd3, 16'h0000, rd);
    chk("ackrst_rd3", {16'd0, rd}, 32'h0000);

    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
